// File: rtl/alu_seq.sv
// alu_seq: multi-byte operation sequencer; issues one 8-bit ALU op per byte, chaining carry via the ALU's registered CO.
// Latency: accept at cycle 0, byte issues at 1..N, result writes at 2..N+1, done pulse at N+2 (plus any stall cycles).
// Backpressure: cmd_ready only in IDLE with rdy high; rdy low freezes state, indices and the pending write (no ALU enable, no write).
//
// Optional feature macro: ALU_SEQ_BCD_EN -- when defined, alu_BCD follows the latched cmd_bcd for ADD/SUB;
// when undefined, alu_BCD is tied low and cmd_bcd is ignored.
//
// Ports:
//   clk, reset        clock and synchronous active-high reset
//   cmd_*             command handshake (valid/ready) with op, byte count-1, carry-in, BCD mode
//   rdy               global stall (low = freeze)
//   rd_idx/rd_a/rd_b  combinational operand read from the scratch register file
//   wr_en/wr_idx/wr_data  result byte write strobe
//   alu_*             control/data to and registered results from the 8-bit ALU
//   done, err         one-cycle status pulses; flag_c/z/v/n registered result flags

module alu_seq #(
  parameter int MAXB = 8,
  parameter int IDXW = 3
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            cmd_valid,
  output logic            cmd_ready,
  input  logic [2:0]      cmd_op,
  input  logic [IDXW-1:0] cmd_len,
  input  logic            cmd_ci,
  input  logic            cmd_bcd,
  input  logic            rdy,
  output logic [IDXW-1:0] rd_idx,
  input  logic [7:0]      rd_a,
  input  logic [7:0]      rd_b,
  output logic            wr_en,
  output logic [IDXW-1:0] wr_idx,
  output logic [7:0]      wr_data,
  output logic [3:0]      alu_op,
  output logic            alu_right,
  output logic [7:0]      alu_AI,
  output logic [7:0]      alu_BI,
  output logic            alu_CI,
  output logic            alu_BCD,
  output logic            alu_RDY,
  input  logic [7:0]      alu_OUT,
  input  logic            alu_CO,
  input  logic            alu_V,
  input  logic            alu_Z,
  input  logic            alu_N,
  output logic            done,
  output logic            err,
  output logic            flag_c,
  output logic            flag_z,
  output logic            flag_v,
  output logic            flag_n
);

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_ROL = 3'b010;
  localparam logic [2:0] OP_ROR = 3'b011;
  localparam logic [2:0] OP_OR  = 3'b100;
  localparam logic [2:0] OP_AND = 3'b101;
  localparam logic [2:0] OP_XOR = 3'b110;
  localparam logic [2:0] OP_RSV = 3'b111;

  // Highest legal byte index; only bites when MAXB is not a power of two.
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(MAXB - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t          state_q, state_d;
  logic [2:0]      op_q;
  logic [IDXW-1:0] len_q;
  logic            ci_q;
  logic [IDXW-1:0] iss_idx_q;   // byte index currently offered to the ALU
  logic            first_q;     // next issue is the first byte of the command
  logic            wr_pend_q;   // ALU holds a result not yet written back
  logic [IDXW-1:0] wr_idx_q;    // index of that pending result
  logic            z_acc_q;     // AND of alu_Z over bytes written so far
  logic            err_q;
  logic            flag_c_q, flag_z_q, flag_v_q, flag_n_q;

  logic            accept;
  logic            start;
  logic            issue;
  logic            last_iss;
  logic [IDXW-1:0] end_idx;
  logic [IDXW-1:0] start_idx;
  logic [IDXW-1:0] len_clamped;

  assign len_clamped = (cmd_len > LAST_IDX) ? LAST_IDX : cmd_len;
  // ROR must see the most significant byte first so the carry shifts downward.
  assign start_idx   = (cmd_op == OP_ROR) ? len_clamped : '0;
  assign end_idx     = (op_q == OP_ROR) ? '0 : len_q;
  assign last_iss    = (iss_idx_q == end_idx);

  // Next-state and handshake/strobe outputs.
  always_comb begin
    state_d   = state_q;
    cmd_ready = 1'b0;
    accept    = 1'b0;
    issue     = 1'b0;
    alu_RDY   = 1'b0;
    wr_en     = 1'b0;
    done      = 1'b0;
    case (state_q)
      S_IDLE: begin
        cmd_ready = rdy;
        if (cmd_valid && rdy) begin
          accept = 1'b1;
          if (cmd_op != OP_RSV) state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (rdy) begin
          issue   = 1'b1;
          alu_RDY = 1'b1;
          wr_en   = wr_pend_q;
          if (last_iss) state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (rdy) begin
          wr_en   = wr_pend_q;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (rdy) begin
          done    = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign start = accept && (cmd_op != OP_RSV);

  // Op decode to the ALU's control encoding.
  always_comb begin
    alu_op    = 4'b0011;
    alu_right = 1'b0;
    case (op_q)
      OP_ADD: alu_op = 4'b0011;
      OP_SUB: alu_op = 4'b0111;
      OP_ROL: alu_op = 4'b1011;
      OP_ROR: begin
        alu_op    = 4'b1111;
        alu_right = 1'b1;
      end
      OP_OR:  alu_op = 4'b1100;
      OP_AND: alu_op = 4'b1101;
      OP_XOR: alu_op = 4'b1110;
      default: alu_op = 4'b0011;
    endcase
  end

  assign rd_idx  = iss_idx_q;
  assign alu_AI  = rd_a;
  assign alu_BI  = rd_b;
  // The ALU's CO only updates on enabled cycles, so it still holds the
  // previous byte's carry across any stall.
  assign alu_CI  = first_q ? ci_q : alu_CO;
  assign wr_idx  = wr_idx_q;
  assign wr_data = alu_OUT;

`ifdef ALU_SEQ_BCD_EN
  logic bcd_q;
  always_ff @(posedge clk) begin
    if (reset)      bcd_q <= 1'b0;
    else if (start) bcd_q <= cmd_bcd;
  end
  assign alu_BCD = bcd_q && ((op_q == OP_ADD) || (op_q == OP_SUB));
`else
  logic unused_bcd;
  assign unused_bcd = cmd_bcd;
  assign alu_BCD    = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      op_q      <= OP_ADD;
      len_q     <= '0;
      ci_q      <= 1'b0;
      iss_idx_q <= '0;
      first_q   <= 1'b0;
      wr_pend_q <= 1'b0;
      wr_idx_q  <= '0;
      z_acc_q   <= 1'b1;
      err_q     <= 1'b0;
      flag_c_q  <= 1'b0;
      flag_z_q  <= 1'b0;
      flag_v_q  <= 1'b0;
      flag_n_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      err_q   <= accept && (cmd_op == OP_RSV);
      if (start) begin
        op_q      <= cmd_op;
        len_q     <= len_clamped;
        ci_q      <= cmd_ci;
        iss_idx_q <= start_idx;
        first_q   <= 1'b1;
        wr_pend_q <= 1'b0;
        z_acc_q   <= 1'b1;
      end
      if (issue) begin
        first_q   <= 1'b0;
        wr_pend_q <= 1'b1;
        wr_idx_q  <= iss_idx_q;
        if (!last_iss) begin
          iss_idx_q <= (op_q == OP_ROR) ? (iss_idx_q - IDXW'(1)) : (iss_idx_q + IDXW'(1));
        end
      end
      if (wr_en) z_acc_q <= z_acc_q & alu_Z;
      // The drain write is the last byte: its ALU flags become the result flags.
      if (wr_en && (state_q == S_DRAIN)) begin
        wr_pend_q <= 1'b0;
        flag_c_q  <= alu_CO;
        flag_v_q  <= alu_V;
        flag_n_q  <= alu_N;
        flag_z_q  <= z_acc_q & alu_Z;
      end
    end
  end

  assign err    = err_q;
  assign flag_c = flag_c_q;
  assign flag_z = flag_z_q;
  assign flag_v = flag_v_q;
  assign flag_n = flag_n_q;

endmodule
